fetch_stage: RTL and testbench



---
 rtl/rnbip_pkg.sv | 29 ++
 rtl/instr_len_decode.sv | 11 +
 rtl/fetch_stage.sv | 149 ++++++++++++++
 tb/tb_fetch_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rnbip_pkg.sv
// Shared RNBIP definitions: bubble opcode, opcode-class patterns, fetch state
// encoding and the instruction-length classifier used by fetch and decode.
package rnbip_pkg;

  localparam logic [7:0] NOP_OPCODE = 8'h00;

  localparam logic [7:0] OP_JUD = 8'h03;
  localparam logic [7:0] OP_CUD = 8'h05;

  // Five-bit prefixes of the operand-carrying opcode groups (low three bits free)
  localparam logic [4:0] PFX_JCD = 5'b0000_1;
  localparam logic [4:0] PFX_CCD = 5'b0011_0;
  localparam logic [4:0] PFX_MVI = 5'b0101_1;

  typedef enum logic {
    S_OP,
    S_OD
  } fetch_state_t;

  function automatic logic is_two_byte(input logic [7:0] opcode);
    logic imm_alu;
    // ADI..XRI: 1xxx_1xxx except the 1111_xxxx page
    imm_alu = opcode[7] && (opcode[6:4] != 3'b111) && opcode[3];
    return (opcode == OP_JUD) || (opcode == OP_CUD) ||
           (opcode[7:3] == PFX_JCD) || (opcode[7:3] == PFX_CCD) ||
           (opcode[7:3] == PFX_MVI) || imm_alu;
  endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Combinational opcode length classifier: two_byte = 1 when an operand byte follows.
module instr_len_decode
  import rnbip_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       two_byte
);

  assign two_byte = is_two_byte(opcode);

endmodule

// File: rtl/fetch_stage.sv
// RNBIP instruction-fetch stage: byte-serial fetch, one/two-byte assembly, stall
// and redirect-with-flush. Optional FETCH_PERF_CNT_EN adds issue/bubble counters.
module fetch_stage #(
  parameter int              PC_W       = 8,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [7:0]      NOP_OPCODE = rnbip_pkg::NOP_OPCODE
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_data,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [7:0]      if_opcode,
  output logic [7:0]      if_operand,
  output logic [PC_W-1:0] if_pc_next,
  output logic            if_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]     perf_issued,
  output logic [15:0]     perf_bubbles
`endif
);

  import rnbip_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      hold_op_q, hold_op_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [7:0]      operand_q, operand_d;
  logic [PC_W-1:0] pc_next_q, pc_next_d;
  logic            valid_q, valid_d;
  logic            two_byte;
  logic [PC_W-1:0] pc_inc;

  instr_len_decode u_len (
    .opcode   (imem_data),
    .two_byte (two_byte)
  );

  assign pc_inc = pc_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_op_d = hold_op_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    if (redirect) begin
      // Flush: any half-assembled instruction is dropped
      pc_d      = redirect_pc;
      state_d   = S_OP;
      opcode_d  = NOP_OPCODE;
      operand_d = 8'h00;
      valid_d   = 1'b0;
    end else if (!stall) begin
      pc_d = pc_inc;
      case (state_q)
        S_OP: begin
          if (two_byte) begin
            hold_op_d = imem_data;
            opcode_d  = NOP_OPCODE;
            operand_d = 8'h00;
            valid_d   = 1'b0;
            state_d   = S_OD;
          end else begin
            opcode_d  = imem_data;
            operand_d = 8'h00;
            pc_next_d = pc_inc;
            valid_d   = 1'b1;
          end
        end
        S_OD: begin
          opcode_d  = hold_op_q;
          operand_d = imem_data;
          pc_next_d = pc_inc;
          valid_d   = 1'b1;
          state_d   = S_OP;
        end
        default: state_d = S_OP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_OP;
      pc_q      <= RESET_PC;
      hold_op_q <= 8'h00;
      opcode_q  <= NOP_OPCODE;
      operand_q <= 8'h00;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_op_q <= hold_op_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
    end
  end

  assign imem_addr  = pc_q;
  assign if_opcode  = opcode_q;
  assign if_operand = operand_q;
  assign if_pc_next = pc_next_q;
  assign if_valid   = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] issued_q, issued_d;
  logic [15:0] bubbles_q, bubbles_d;
  logic        load;

  // An edge "loads" the output bundle unless the stage is held by stall
  assign load = redirect || !stall;

  always_comb begin
    issued_d  = issued_q;
    bubbles_d = bubbles_q;
    if (load) begin
      if (valid_d) begin
        if (issued_q != 16'hFFFF) issued_d = issued_q + 16'd1;
      end else begin
        if (bubbles_q != 16'hFFFF) bubbles_d = bubbles_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q  <= 16'h0000;
      bubbles_q <= 16'h0000;
    end else begin
      issued_q  <= issued_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_issued  = issued_q;
  assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage and exhaustive instr_len_decode check.
module tb_fetch_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       stall;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic [7:0] if_opcode;
  logic [7:0] if_operand;
  logic [7:0] if_pc_next;
  logic       if_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_issued;
  logic [15:0] perf_bubbles;
`endif

  logic [7:0] rom [256];
  logic [7:0] dec_op;
  logic       dec_two;

  int cmp_count = 0;
  int err_count = 0;

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr];

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_opcode   (if_opcode),
    .if_operand  (if_operand),
    .if_pc_next  (if_pc_next),
    .if_valid    (if_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_issued  (perf_issued),
    .perf_bubbles (perf_bubbles)
`endif
  );

  instr_len_decode u_dec (
    .opcode   (dec_op),
    .two_byte (dec_two)
  );

  // Bundle view: {opcode, operand, pc_next, valid, imem_addr}
  logic [32:0] obs;
  assign obs = {if_opcode, if_operand, if_pc_next, if_valid, imem_addr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [32:0] exp;
    for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
    rom[0] = 8'h00;
    rom[1] = 8'h02;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    tick(); tick();
    exp = {8'h00, 8'h00, 8'h00, 1'b0, 8'h00};
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL reset_state: got %h expected %h", obs, exp);
    end
    rst = 1'b0;
    tick();
    exp = {8'h00, 8'h00, 8'h01, 1'b1, 8'h01};
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL one_byte_first: got %h expected %h", obs, exp);
    end
    tick();
    exp = {8'h02, 8'h00, 8'h02, 1'b1, 8'h02};
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL one_byte_second: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_two_byte();
    logic [32:0] exp;
    rom[4] = 8'h8B;
    rom[5] = 8'h3C;
    redirect = 1'b1; redirect_pc = 8'h04;
    tick();
    redirect = 1'b0;
    exp = {8'h00, 8'h00, 8'h02, 1'b0, 8'h04};
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL redirect_bubble: got %h expected %h", obs, exp);
    end
    tick();
    exp = {8'h00, 8'h00, 8'h02, 1'b0, 8'h05};
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL two_byte_bubble: got %h expected %h", obs, exp);
    end
    tick();
    exp = {8'h8B, 8'h3C, 8'h06, 1'b1, 8'h06};
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL two_byte_issue: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_stall();
    logic [32:0] exp;
    rom[8'h10] = 8'h59;
    rom[8'h11] = 8'hA5;
    rom[8'h12] = 8'h01;
    redirect = 1'b1; redirect_pc = 8'h10;
    tick();
    redirect = 1'b0;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = {8'h00, 8'h00, 8'h06, 1'b0, 8'h11};
      cmp_count++;
      if (obs !== exp) begin
        err_count++;
        $display("[TB] FAIL stall_in_od[%0d]: got %h expected %h", i, obs, exp);
      end
    end
    stall = 1'b0;
    tick();
    exp = {8'h59, 8'hA5, 8'h12, 1'b1, 8'h12};
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL stall_release: got %h expected %h", obs, exp);
    end
    stall = 1'b1;
    tick();
    stall = 1'b0;
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL stall_hold_valid: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_redirect_over_stall();
    logic [32:0] exp;
    rom[8'h20] = 8'h03;
    rom[8'h21] = 8'h99;
    rom[8'h40] = 8'h12;
    redirect = 1'b1; redirect_pc = 8'h20;
    tick();
    redirect = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 8'h40; stall = 1'b1;
    tick();
    redirect = 1'b0; stall = 1'b0;
    exp = {8'h00, 8'h00, 8'h12, 1'b0, 8'h40};
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL redirect_flush: got %h expected %h", obs, exp);
    end
    tick();
    exp = {8'h12, 8'h00, 8'h41, 1'b1, 8'h41};
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL redirect_target_issue: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_wrap();
    logic [32:0] exp;
    rom[8'hFF] = 8'h0B;
    rom[8'h00] = 8'h77;
    redirect = 1'b1; redirect_pc = 8'hFF;
    tick();
    redirect = 1'b0;
    tick();
    exp = {8'h00, 8'h00, 8'h41, 1'b0, 8'h00};
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL wrap_bubble: got %h expected %h", obs, exp);
    end
    tick();
    exp = {8'h0B, 8'h77, 8'h01, 1'b1, 8'h01};
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL wrap_issue: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_reset_mid_od();
    logic [32:0] exp;
    rom[8'h30] = 8'h05;
    redirect = 1'b1; redirect_pc = 8'h30;
    tick();
    redirect = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp = {8'h00, 8'h00, 8'h00, 1'b0, 8'h00};
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL reset_in_od: got %h expected %h", obs, exp);
    end
    tick();
    exp = {8'h77, 8'h00, 8'h01, 1'b1, 8'h01};
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL after_reset_in_od: got %h expected %h", obs, exp);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    rom[8'h00] = 8'h77;
    rom[8'h01] = 8'h08;
    rom[8'h02] = 8'h44;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp_count++;
    if ({perf_issued, perf_bubbles} !== 32'h0) begin
      err_count++;
      $display("[TB] FAIL perf_reset: got %h/%h expected 0000/0000", perf_issued, perf_bubbles);
    end
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 8'h50;
    tick();
    redirect = 1'b0;
    stall = 1'b1;
    tick();
    stall = 1'b0;
    cmp_count++;
    if (perf_issued !== 16'd2 || perf_bubbles !== 16'd2) begin
      err_count++;
      $display("[TB] FAIL perf_counts: got %0d/%0d expected 2/2", perf_issued, perf_bubbles);
    end
  endtask
`endif

  task automatic test_len_decode();
    logic exp;
    for (int i = 0; i < 256; i++) begin
      dec_op = i[7:0];
      exp = (i == 3) || (i == 5) || (i >= 8 && i <= 15) || (i >= 48 && i <= 55) ||
            (i >= 88 && i <= 95) || (i >= 128 && i <= 239 && (i % 16) >= 8);
      #1;
      cmp_count++;
      if (dec_two !== exp) begin
        err_count++;
        $display("[TB] FAIL len_decode op=%h: got %b expected %b", dec_op, dec_two, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; dec_op = 8'h00;
    test_reset();
    test_two_byte();
    test_stall();
    test_redirect_over_stall();
    test_wrap();
    test_reset_mid_od();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    test_len_decode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
